// File: rtl/rx_fsm.sv
// rx_fsm: deserialises the sck_rx/data_rx/latch_rx link into W-bit words, MSB first; RX_SYNC_EN adds 2-flop input synchronisers.
// Latency: rx_valid rises 2 clk after latch_rx is first sampled high (4 clk with RX_SYNC_EN).
// Backpressure: single valid/ready holding register; a good word committed while it is full and not accepted is dropped and sets sticky overrun.
module rx_fsm #(
    parameter int DATA_WIDTH_BASE = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sck_rx,
    input  logic                              data_rx,
    input  logic                              latch_rx,
    input  logic                              rx_ready,
    input  logic                              clr_ovr,
    output logic [(1 << DATA_WIDTH_BASE)-1:0] rx_data,
    output logic                              rx_valid,
    output logic                              frame_err,
    output logic                              overrun,
    output logic                              busy
);

    localparam int W  = 1 << DATA_WIDTH_BASE;
    localparam int CW = DATA_WIDTH_BASE + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(W);

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_SHIFT  = 2'd1,
        RX_COMMIT = 2'd2
    } rx_state_t;

    rx_state_t       state, state_nxt;
    logic            sck_in, data_in, lat_in;
    logic            s_sck, s_data, s_lat, d_sck, d_lat;
    logic [W-1:0]    shift_reg;
    logic [CW-1:0]   cnt;
    logic            xbit;
    logic            rise_sck, rise_lat, take_bit, word_ok;
    logic            first_bit, shift_en, commit;
    logic            load, drop;

`ifdef RX_SYNC_EN
    logic [1:0] sck_sync, data_sync, lat_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_sync  <= '0;
            data_sync <= '0;
            lat_sync  <= '0;
        end else begin
            sck_sync  <= {sck_sync[0], sck_rx};
            data_sync <= {data_sync[0], data_rx};
            lat_sync  <= {lat_sync[0], latch_rx};
        end
    end

    assign sck_in  = sck_sync[1];
    assign data_in = data_sync[1];
    assign lat_in  = lat_sync[1];
`else
    assign sck_in  = sck_rx;
    assign data_in = data_rx;
    assign lat_in  = latch_rx;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_sck  <= 1'b0;
            s_data <= 1'b0;
            s_lat  <= 1'b0;
            d_sck  <= 1'b0;
            d_lat  <= 1'b0;
        end else begin
            s_sck  <= sck_in;
            s_data <= data_in;
            s_lat  <= lat_in;
            d_sck  <= s_sck;
            d_lat  <= s_lat;
        end
    end

    assign rise_sck = s_sck & ~d_sck;
    assign rise_lat = s_lat & ~d_lat;
    // an sck rise while the latch is high belongs to no frame
    assign take_bit = rise_sck & ~s_lat;
    assign word_ok  = (cnt == CNT_FULL) && !xbit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        first_bit = 1'b0;
        shift_en  = 1'b0;
        commit    = 1'b0;
        frame_err = 1'b0;
        case (state)
            RX_IDLE: begin
                if (take_bit) begin
                    first_bit = 1'b1;
                    state_nxt = RX_SHIFT;
                end else if (rise_lat) begin
                    frame_err = 1'b1;
                end
            end
            RX_SHIFT: begin
                if (rise_lat) begin
                    state_nxt = RX_COMMIT;
                end else if (take_bit) begin
                    shift_en = 1'b1;
                end
            end
            RX_COMMIT: begin
                commit    = 1'b1;
                frame_err = !word_ok;
                // back-to-back frame: its first bit may land in the commit cycle
                if (take_bit) begin
                    first_bit = 1'b1;
                    state_nxt = RX_SHIFT;
                end else begin
                    state_nxt = RX_IDLE;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            cnt       <= '0;
            xbit      <= 1'b0;
        end else if (first_bit) begin
            shift_reg <= {shift_reg[W-2:0], s_data};
            cnt       <= CW'(1);
            xbit      <= 1'b0;
        end else if (commit) begin
            cnt  <= '0;
            xbit <= 1'b0;
        end else if (shift_en) begin
            if (cnt == CNT_FULL) begin
                xbit <= 1'b1;
            end else begin
                shift_reg <= {shift_reg[W-2:0], s_data};
                cnt       <= cnt + CW'(1);
            end
        end
    end

    assign load = commit && word_ok && (!rx_valid || rx_ready);
    assign drop = commit && word_ok && rx_valid && !rx_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (load) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            // a drop in the same cycle as a clear keeps the flag set
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign busy = (state == RX_SHIFT);

endmodule
